pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_if.sv | 36 +++
 rtl/pipeline_ctrl_hazard.sv | 16 +
 rtl/pipeline_ctrl.sv | 134 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    // Register-file index width (x0..x31)
    localparam int REG_W         = 5;
    // Width of the internal memory-wait counter
    localparam int INTERNAL_BITS = 16;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: hazard inputs from the datapath, enables/flushes back.
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
    import pipeline_ctrl_pkg::*;

    reg_idx_t           id_rs1;
    reg_idx_t           id_rs2;
    logic               ex_mem_read;
    reg_idx_t           ex_rd;
    logic               mem_branch_taken;
    logic               mem_access;
    logic               dm_ready;
    logic               pc_en;
    logic               ifid_en;
    logic               ifid_flush;
    logic               idex_flush;
    logic               exmem_en;
    logic               exmem_flush;
    logic               memwb_flush;
    logic [CNT_W-1:0]   stall_cnt;
    logic               dm_err;

    // Datapath side: supplies hazard information, consumes control
    modport master (
        output id_rs1, id_rs2, ex_mem_read, ex_rd, mem_branch_taken, mem_access, dm_ready,
        input  pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, memwb_flush,
        input  stall_cnt, dm_err
    );

    // Controller side
    modport slave (
        input  id_rs1, id_rs2, ex_mem_read, ex_rd, mem_branch_taken, mem_access, dm_ready,
        output pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, exmem_flush, memwb_flush,
        output stall_cnt, dm_err
    );

endinterface

// File: rtl/pipeline_ctrl_hazard.sv
// Load-use comparator: load in EX whose destination feeds the instruction in ID.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic     i_mem_read,
    input  reg_idx_t i_ex_rd,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    output logic     o_stall
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign o_stall = i_mem_read && (i_ex_rd != '0) &&
                     ((i_ex_rd == i_rs1) || (i_ex_rd == i_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: memory-wait freeze, branch flush, load-use stall.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   bus
);

    localparam logic [INTERNAL_BITS-1:0] LP_WAIT_LAST = INTERNAL_BITS'(TIMEOUT - 1);

    state_t                   r_state;
    state_t                   w_next;
    logic [INTERNAL_BITS-1:0] r_wait_cnt;
    logic [CNT_W-1:0]         r_stall_cnt;
    logic                     r_dm_err;
    logic                     r_br_pend;

    logic w_load_use, w_wait_start, w_wait_last, w_done, w_timeout;
    logic w_pc_en, w_ifid_en, w_exmem_en;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;

    hazard_detect u_hazard (
        .i_mem_read (bus.ex_mem_read),
        .i_ex_rd    (bus.ex_rd),
        .i_rs1      (bus.id_rs1),
        .i_rs2      (bus.id_rs2),
        .o_stall    (w_load_use)
    );

    assign w_wait_start = (r_state == RUN) && bus.mem_access && !bus.dm_ready;
    assign w_wait_last  = (r_wait_cnt == LP_WAIT_LAST);
    // Completion is either the ready strobe or the abort on the last allowed cycle
    assign w_done       = (r_state == MEM_WAIT) && (bus.dm_ready || w_wait_last);
    assign w_timeout    = (r_state == MEM_WAIT) && !bus.dm_ready && w_wait_last;

    // Next state and control outputs; priority is memory wait > branch > load-use
    always_comb begin
        w_next        = r_state;
        w_pc_en       = 1'b1;
        w_ifid_en     = 1'b1;
        w_exmem_en    = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        if (!rst_n) begin
            w_next        = RUN;
            w_pc_en       = 1'b0;
            w_ifid_en     = 1'b0;
            w_exmem_en    = 1'b0;
            w_ifid_flush  = 1'b1;
            w_idex_flush  = 1'b1;
            w_exmem_flush = 1'b1;
            w_memwb_flush = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_wait_start) begin
                        w_next        = MEM_WAIT;
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_exmem_en    = 1'b0;
                        w_memwb_flush = 1'b1;
                    end else if (bus.mem_branch_taken) begin
                        w_ifid_flush  = 1'b1;
                        w_idex_flush  = 1'b1;
                        w_exmem_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_idex_flush  = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (w_done) begin
                        w_next = RUN;
                        // A branch that arrived during the wait takes effect now
                        if (bus.mem_branch_taken || r_br_pend) begin
                            w_ifid_flush  = 1'b1;
                            w_idex_flush  = 1'b1;
                            w_exmem_flush = 1'b1;
                        end
                    end else begin
                        w_pc_en       = 1'b0;
                        w_ifid_en     = 1'b0;
                        w_exmem_en    = 1'b0;
                        w_memwb_flush = 1'b1;
                    end
                end
                default: w_next = RUN;
            endcase
        end
    end

    // State, wait counter, stall statistics, sticky error and deferred branch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_dm_err    <= 1'b0;
            r_br_pend   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_wait_start)
                r_wait_cnt <= '0;
            else if (r_state == MEM_WAIT)
                r_wait_cnt <= r_wait_cnt + 1'b1;
            if (!w_pc_en && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_timeout)
                r_dm_err <= 1'b1;
            if (w_done)
                r_br_pend <= 1'b0;
            else if ((w_wait_start || (r_state == MEM_WAIT)) && bus.mem_branch_taken)
                r_br_pend <= 1'b1;
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.ifid_en     = w_ifid_en;
    assign bus.exmem_en    = w_exmem_en;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_flush = w_exmem_flush;
    assign bus.memwb_flush = w_memwb_flush;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.dm_err      = r_dm_err;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed vector bench for pipeline_ctrl (TIMEOUT=4, 4-bit stall counter).
module tb_pipeline_ctrl;

    localparam int CW = 4;

    // Control bundle order: {pc_en, ifid_en, exmem_en, ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [6:0] RST  = 7'b000_1111;
    localparam logic [6:0] IDLE = 7'b111_0000;
    localparam logic [6:0] FRZ  = 7'b000_0001;
    localparam logic [6:0] BR   = 7'b111_1110;
    localparam logic [6:0] LU   = 7'b001_0100;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.TIMEOUT(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1, rs2, exrd;
        logic       emr, br, ma, rdy;
        logic [6:0] exp;
        int         cnt;
        logic       err;
        logic       chk;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(string nm, int rst, int rs1, int rs2, int emr, int exrd,
                                int br, int ma, int rdy, logic [6:0] exp, int cnt, int err, int chk);
        vec_t v;
        v.name = nm;       v.rst = 1'(rst);
        v.rs1  = 5'(rs1);  v.rs2 = 5'(rs2);  v.exrd = 5'(exrd);
        v.emr  = 1'(emr);  v.br  = 1'(br);   v.ma   = 1'(ma);  v.rdy = 1'(rdy);
        v.exp  = exp;      v.cnt = cnt;      v.err  = 1'(err); v.chk = 1'(chk);
        vq.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        rst_n                = v.rst;
        bus.id_rs1           = v.rs1;
        bus.id_rs2           = v.rs2;
        bus.ex_mem_read      = v.emr;
        bus.ex_rd            = v.exrd;
        bus.mem_branch_taken = v.br;
        bus.mem_access       = v.ma;
        bus.dm_ready         = v.rdy;
    endtask

    task automatic check(input string nm, input int row, input logic [6:0] exp,
                         input int cnt, input logic err, input logic chk);
        logic [6:0] got;
        got = {bus.pc_en, bus.ifid_en, bus.exmem_en, bus.ifid_flush,
               bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s row%0d ctrl got=%b want=%b", nm, row, got, exp);
        end
        if (chk) begin
            total++;
            if (bus.stall_cnt !== CW'(cnt)) begin
                bad++;
                $display("FAIL %s row%0d stall_cnt got=%0d want=%0d", nm, row, bus.stall_cnt, cnt);
            end
            total++;
            if (bus.dm_err !== err) begin
                bad++;
                $display("FAIL %s row%0d dm_err got=%b want=%b", nm, row, bus.dm_err, err);
            end
        end
    endtask

    initial begin
        vec_t lu_v, idle_v;

        //   name          rst rs1 rs2 emr exrd br ma rdy exp   cnt err chk
        add("rst0",         0,  0,  0,  0,  0,  0, 0, 0,  RST,   0, 0, 0);
        add("rst1",         0,  0,  0,  0,  0,  0, 0, 0,  RST,   0, 0, 1);
        add("idle",         1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  0, 0, 1);
        add("lu_rs2",       1,  3,  5,  1,  5,  0, 0, 0,  LU,    0, 0, 1);
        add("lu_after",     1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  1, 0, 1);
        add("x0",           1,  0,  0,  1,  0,  0, 0, 0,  IDLE,  1, 0, 1);
        add("lu_rs1",       1,  7,  2,  1,  7,  0, 0, 0,  LU,    1, 0, 1);
        add("no_load",      1,  7,  2,  0,  7,  0, 0, 0,  IDLE,  2, 0, 1);
        add("br_and_lu",    1,  9,  0,  1,  9,  1, 0, 0,  BR,    2, 0, 1);
        add("idle2",        1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  2, 0, 1);
        add("rst_again",    0,  0,  0,  0,  0,  0, 0, 0,  RST,   2, 0, 1);
        add("idle3",        1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  0, 0, 1);
        add("mem_fast",     1,  0,  0,  0,  0,  0, 1, 1,  IDLE,  0, 0, 1);
        add("wait_e",       1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   0, 0, 1);
        add("wait_1",       1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   1, 0, 1);
        add("wait_2",       1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   2, 0, 1);
        add("wait_rdy",     1,  0,  0,  0,  0,  0, 1, 1,  IDLE,  3, 0, 1);
        add("wait_done",    1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  3, 0, 1);
        add("to_e",         1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   3, 0, 1);
        add("to_0",         1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   4, 0, 1);
        add("to_1",         1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   5, 0, 1);
        add("to_2",         1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   6, 0, 1);
        add("to_abort",     1,  0,  0,  0,  0,  0, 1, 0,  IDLE,  7, 0, 1);
        add("to_err",       1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  7, 1, 1);
        add("to_run_lu",    1,  4,  0,  1,  4,  0, 0, 0,  LU,    7, 1, 1);
        add("to_sticky",    1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  8, 1, 1);
        add("dbr_e",        1,  0,  0,  0,  0,  1, 1, 0,  FRZ,   8, 1, 1);
        add("dbr_w",        1,  0,  0,  0,  0,  0, 1, 0,  FRZ,   9, 1, 1);
        add("dbr_apply",    1,  0,  0,  0,  0,  0, 1, 1,  BR,   10, 1, 1);
        add("dbr_idle",     1,  0,  0,  0,  0,  0, 0, 0,  IDLE, 10, 1, 1);
        add("rmw_e",        1,  0,  0,  0,  0,  0, 1, 0,  FRZ,  10, 1, 1);
        add("rmw_w",        1,  0,  0,  0,  0,  0, 1, 0,  FRZ,  11, 1, 1);
        add("rmw_rst",      0,  0,  0,  0,  0,  0, 1, 0,  RST,  12, 1, 1);
        add("rmw_run",      1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  0, 0, 1);
        add("rmw_lu",       1,  6,  0,  1,  6,  0, 0, 0,  LU,    0, 0, 1);
        add("rmw_idle",     1,  0,  0,  0,  0,  0, 0, 0,  IDLE,  1, 0, 1);

        foreach (vq[i]) begin
            drive(vq[i]);
            @(negedge clk);
            check(vq[i].name, i, vq[i].exp, vq[i].cnt, vq[i].err, vq[i].chk);
            @(posedge clk);
            #1;
        end

        // Saturation: a persistent load-use keeps pc_en low every cycle
        lu_v   = vq[34];
        idle_v = vq[35];
        for (int k = 0; k < 20; k++) begin
            drive(lu_v);
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        drive(lu_v);
        @(negedge clk);
        check("sat", 0, LU, 15, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(idle_v);
        @(negedge clk);
        check("sat_hold", 1, IDLE, 15, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
